// File: rtl/prbs6_pkg.sv
// Shared PRBS6 definitions: FSM states, register length, feedback taps and period.
// Optional error counter in the checker is built only when PRBS6_CHK_ERRCNT_EN is defined.
package prbs6_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int PRBS_LEN    = 6;
    localparam int TAP_A       = 3;
    localparam int TAP_B       = 5;
    localparam int PRBS_PERIOD = 14;

    // h[0] is the newest bit, so h[3] is s[n-4] and h[5] is s[n-6].
    function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] hist);
        return hist[TAP_A] ^ hist[TAP_B];
    endfunction

endpackage

// File: rtl/prbs6_predictor.sv
// Self-synchronising PRBS6 history and next-bit prediction; match is combinational, history updates on each valid.
// No backpressure: every in_valid sample is shifted in, errored or not.
module prbs6_predictor
    import prbs6_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_bit,
    output logic pred_vld,
    output logic match
);

    localparam logic [2:0] FILL_FULL = 3'(PRBS_LEN);

    logic [PRBS_LEN-1:0] hist;
    logic [2:0]          fill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist <= {hist[PRBS_LEN-2:0], in_bit};
            if (fill != FILL_FULL) begin
                fill <= fill + 3'd1;
            end
        end
    end

    // A prediction is only meaningful once six real samples sit in the history.
    assign pred_vld = in_valid && (fill == FILL_FULL);
    assign match    = (in_bit == prbs_predict(hist));

endmodule

// File: rtl/prbs6_checker.sv
// PRBS6 lock/error checker (PRBS6_CHK_ERRCNT_EN builds err_cnt); outputs registered, one cycle after the sample.
// No backpressure: samples are accepted whenever in_valid is high.
module prbs6_checker
    import prbs6_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] match_cnt;
    logic [7:0] match_cnt_nxt;
    logic [3:0] miss_cnt;
    logic [3:0] miss_cnt_nxt;
    logic       err_nxt;
    logic       pred_vld;
    logic       match;

    prbs6_predictor u_pred (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .pred_vld (pred_vld),
        .match    (match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEARCH;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err       <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_cnt_nxt;
            miss_cnt  <= miss_cnt_nxt;
            err       <= err_nxt;
            locked    <= (state_nxt == LOCKED);
        end
    end

    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        miss_cnt_nxt  = miss_cnt;
        err_nxt       = 1'b0;
        if (pred_vld) begin
            case (state)
                SEARCH: begin
                    if (!match) begin
                        match_cnt_nxt = '0;
                    end else if (match_cnt == LOCK_LAST) begin
                        state_nxt     = LOCKED;
                        match_cnt_nxt = '0;
                        miss_cnt_nxt  = '0;
                    end else begin
                        match_cnt_nxt = match_cnt + 8'd1;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_cnt_nxt = '0;
                    end else begin
                        // The losing mismatch is still a LOCKED error and is counted.
                        err_nxt = 1'b1;
                        if (miss_cnt == LOSS_LAST) begin
                            state_nxt     = SEARCH;
                            match_cnt_nxt = '0;
                            miss_cnt_nxt  = '0;
                        end else begin
                            miss_cnt_nxt = miss_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PRBS6_CHK_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (clr_cnt) begin
            err_cnt_q <= '0;
        end else if (err_nxt && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_prbs6_checker.sv
// Bench for prbs6_checker: directed PRBS6 streams, a sample-level reference model and literal pins.
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
module tb_prbs6_checker;

`ifdef PRBS6_CHK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int LOCK_CNT = 8;
    localparam int LOSS_CNT = 3;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_bit   = 1'b0;
    logic        clr_cnt  = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic        locked2;
    logic        err2;
    logic [1:0]  err_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prbs6_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    prbs6_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference stream from the all-ones seed: 1111 0000 1100 11, bit i = s[i].
    function automatic bit prbs(input int k);
        bit [13:0] pat;
        pat = 14'b11001100001111;
        return pat[k % 14];
    endfunction

    // Model: keep the last six received bits, predict s[n-4]^s[n-6], run the lock rules.
    bit m_rx[$];
    bit m_locked;
    bit m_err;
    bit m_hit;
    bit m_bump;
    int m_run;
    int m_miss;
    int m_cnt16;
    int m_cnt2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rx.delete();
            m_locked = 1'b0;
            m_err    = 1'b0;
            m_run    = 0;
            m_miss   = 0;
            m_cnt16  = 0;
            m_cnt2   = 0;
        end else begin
            m_err  = 1'b0;
            m_bump = 1'b0;
            if (in_valid) begin
                if (m_rx.size() >= 6) begin
                    m_hit = (in_bit == (m_rx[m_rx.size()-4] ^ m_rx[m_rx.size()-6]));
                    if (!m_locked) begin
                        m_run = m_hit ? m_run + 1 : 0;
                        if (m_run >= LOCK_CNT) begin
                            m_locked = 1'b1;
                            m_miss   = 0;
                        end
                    end else if (m_hit) begin
                        m_miss = 0;
                    end else begin
                        m_err  = 1'b1;
                        m_bump = 1'b1;
                        m_miss = m_miss + 1;
                        if (m_miss >= LOSS_CNT) begin
                            m_locked = 1'b0;
                            m_run    = 0;
                        end
                    end
                end
                m_rx.push_back(in_bit);
                if (m_rx.size() > 6) void'(m_rx.pop_front());
            end
            if (clr_cnt) begin
                m_cnt16 = 0;
                m_cnt2  = 0;
            end else if (m_bump) begin
                if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
                if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("model_locked", locked, m_locked);
        check("model_err", err, m_err);
        check("model_err_cnt", err_cnt, CNT_EN ? m_cnt16 : 0);
        check("model_locked_w2", locked2, m_locked);
        check("model_err_w2", err2, m_err);
        check("model_err_cnt_w2", err_cnt2, CNT_EN ? m_cnt2 : 0);
    end

    task automatic step(input bit v, input bit b, input bit c);
        in_valid = v;
        in_bit   = b;
        clr_cnt  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0);
    endtask

    int lock_idx;
    int fall_idx;
    int rise_idx;
    int nerr;
    bit dropped;
    int err_idx[$];

    initial begin
        #1 rst = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        check("reset_locked", locked, 0);
        check("reset_err", err, 0);
        check("reset_err_cnt", err_cnt, 0);
        rst = 1'b1;
        step(0, 0, 0);

        // Clean continuous stream.
        lock_idx = -1;
        nerr     = 0;
        for (int k = 0; k < 200; k++) begin
            step(1, prbs(k), 0);
            if (locked && lock_idx < 0) lock_idx = k;
            if (err) nerr++;
        end
        check("clean_lock_sample", lock_idx, 13);
        check("clean_err_pulses", nerr, 0);
        check("clean_err_cnt", err_cnt, 0);

        // Single flipped bit at sample 40.
        do_reset();
        err_idx.delete();
        dropped = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step(1, prbs(k) ^ (k == 40), 0);
            if (err) err_idx.push_back(k);
            if (k > 13 && !locked) dropped = 1'b1;
        end
        check("flip_err_pulses", err_idx.size(), 3);
        check("flip_err_first", (err_idx.size() > 0) ? err_idx[0] : -1, 40);
        check("flip_err_second", (err_idx.size() > 1) ? err_idx[1] : -1, 44);
        check("flip_err_third", (err_idx.size() > 2) ? err_idx[2] : -1, 46);
        check("flip_err_cnt", err_cnt, CNT_EN ? 3 : 0);
        check("flip_lock_kept", dropped, 0);

        // Burst of three inverted samples forces loss of lock, then relock.
        do_reset();
        fall_idx = -1;
        rise_idx = -1;
        for (int k = 0; k < 120; k++) begin
            step(1, prbs(k) ^ (k >= 60 && k <= 62), 0);
            if (k > 13 && !locked && fall_idx < 0) fall_idx = k;
            if (fall_idx >= 0 && locked && rise_idx < 0) rise_idx = k;
        end
        check("burst_fall_sample", fall_idx, 62);
        check("burst_rise_sample", rise_idx, 76);
        check("burst_err_cnt", err_cnt, CNT_EN ? 3 : 0);

        // Idle cycle between every sample, with a garbage bit on the idle cycle.
        do_reset();
        lock_idx = -1;
        for (int k = 0; k < 40; k++) begin
            step(0, ~prbs(k), 0);
            step(1, prbs(k), 0);
            if (locked && lock_idx < 0) lock_idx = k;
        end
        check("gapped_lock_sample", lock_idx, 13);

        // Repeated flips 20 apart, then clear coinciding with an error.
        do_reset();
        for (int k = 0; k < 120; k++) begin
            step(1, prbs(k) ^ (k == 40 || k == 60 || k == 80 || k == 100), (k == 100));
            if (k == 99) begin
                check("sat_err_cnt_w2", err_cnt2, CNT_EN ? 3 : 0);
                check("sat_err_cnt_w16", err_cnt, CNT_EN ? 9 : 0);
            end
            if (k == 100) begin
                check("clr_err_pulse", err, 1);
                check("clr_priority", err_cnt, 0);
                check("clr_priority_w2", err_cnt2, 0);
            end
        end
        check("post_clr_err_cnt", err_cnt, CNT_EN ? 2 : 0);

        // Asynchronous reset while locked with an error pulse outstanding.
        do_reset();
        for (int k = 0; k < 30; k++) begin
            step(1, prbs(k) ^ (k == 20 || k == 29), 0);
        end
        check("pre_reset_locked", locked, 1);
        check("pre_reset_err", err, 1);
        check("pre_reset_err_cnt", err_cnt, CNT_EN ? 4 : 0);
        rst = 1'b0;
        #1;
        check("async_reset_locked", locked, 0);
        check("async_reset_err", err, 0);
        check("async_reset_err_cnt", err_cnt, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b1;
        lock_idx = -1;
        for (int k = 0; k < 30; k++) begin
            step(1, prbs(k), 0);
            if (locked && lock_idx < 0) lock_idx = k;
        end
        check("relock_sample", lock_idx, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs6_checker.md
# prbs6_checker

Receive-side companion to the 6-bit PRBS generator. It takes the generator's serial output (the MSB of the register, one bit per valid cycle) and rebuilds the expected sequence from the received bits themselves, so it synchronises without a seed. It then reports lock and counts bit errors. It sits at the far end of a serial test link or loopback path, behind whatever samples the line.

## Interface
- LOCK_CNT, 8: consecutive matching predictions required to enter LOCKED (range 1..255)
- LOSS_CNT, 3: consecutive mismatches in LOCKED that force a return to SEARCH (range 1..15)
- CNT_W, 16: error counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset; clock and reset are the only timing references
- in_valid  in  1  in_bit carries a sample this cycle
- in_bit  in  1  received serial bit
- clr_cnt  in  1  synchronous clear of err_cnt
- locked  out  1  checker is in LOCKED
- err  out  1  one-cycle pulse per mismatching sample while LOCKED
- err_cnt  out  CNT_W  saturating count of LOCKED mismatches

## Operation
- Sequence law: s[n] = s[n-4] ^ s[n-6]. From the generator's all-ones seed, the stream repeats with period 14: 1111 0000 1100 11.
- History: a 6-bit shift register h. It shifts in in_bit on every in_valid, including errored bits, so the checker is self-synchronising.
- Fill counter (0..6) tracks how many samples are in h. Predictions start once the fill counter reaches 6, which is the 7th valid sample.
- Prediction: exp = h[3] ^ h[5], where h[0] is the newest bit. match = (in_bit == exp).
- State SEARCH (reset state):
  - match increments match_cnt.
  - mismatch clears match_cnt.
  - match_cnt reaching LOCK_CNT moves the block to LOCKED and clears miss_cnt.
  - No err pulse and no err_cnt change in this state.
- State LOCKED:
  - mismatch pulses err, increments err_cnt and increments miss_cnt.
  - match clears miss_cnt.
  - miss_cnt reaching LOSS_CNT moves the block to SEARCH and clears match_cnt. History and fill are kept.
- err_cnt saturates at 2^CNT_W-1.
- clr_cnt has priority over a simultaneous increment; err_cnt is 0 afterwards.
- Cycles with in_valid low change no state, counters or history, and err stays low.
- One flipped bit while LOCKED produces exactly 3 mismatches, at samples n, n+4 and n+6. Lock is kept for LOSS_CNT >= 2.

## Timing
- Reset values: locked=0, err=0, err_cnt=0, state=SEARCH, h=0, fill=0, match_cnt=0, miss_cnt=0.
- Reset asserted mid-operation clears everything immediately, asynchronously. Resynchronisation starts from an empty history.
- All outputs are registered. Latency is one cycle: a sample at edge k drives err, locked and err_cnt after edge k.
- Clean continuous stream: locked rises after the valid edge of sample 6+LOCK_CNT-1 (0-based). For LOCK_CNT=8 that is sample 13.
- In-band input only; there is no backpressure.

## Configuration
- PRBS6_CHK_ERRCNT_EN:
  - Defined: err_cnt register, saturation logic and clr_cnt are built as specified.
  - Undefined: err_cnt is tied to 0 and clr_cnt is ignored.
  - err, locked and the FSM behave identically either way.

## Structure
- Package prbs6_pkg holds:
  - state enum {SEARCH, LOCKED}
  - PRBS_LEN=6
  - tap indices TAP_A=3, TAP_B=5
  - period constant 14
- Sub-module prbs6_predictor contains the history register, fill counter and exp/match generation.
- prbs6_checker keeps the FSM, match/miss counters and error counter.

## Test plan
- Reset, then a continuous clean stream from the all-ones seed (1111 0000 1100 11 …) -> locked rises after sample 13; err never pulses; err_cnt=0 after 200 samples.
- Locked, flip sample 40 -> err pulses on samples 40, 44 and 46; err_cnt=3; locked stays 1.
- Locked, invert samples 60..62 (LOSS_CNT=3) -> locked falls after sample 62. With clean input afterwards, locked re-rises no later than 8 predictions after the last bad bit leaves h.
- Clean stream with in_valid low every other cycle -> same lock sample index as the continuous case; idle cycles change nothing.
- CNT_W=2, locked, repeated single flips spaced 20 samples apart -> err_cnt saturates at 3. Asserting clr_cnt in the same cycle as an error leaves err_cnt=0.
- Reset asserted while LOCKED -> locked, err and err_cnt are 0 immediately. Relock takes the full 14 samples after release.
